// File: rtl/systolic_array_nxn.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_nxn
// Brief    : Output-stationary NxN systolic multiplier, C = A*B or C += A*B.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_array_nxn #(
    parameter int N  = 8,
    parameter int DW = 8,
    parameter int AW = 32
) (
    input  logic                        i_clk,
    input  logic                        i_arst_n,
    input  logic [N-1:0][N-1:0][DW-1:0] i_a,
    input  logic [N-1:0][N-1:0][DW-1:0] i_b,
    input  logic                        i_validInput,
    output logic                        o_readyInput,
    input  logic                        i_accumulate,
    input  logic                        i_signed,
    output logic [N-1:0][N-1:0][AW-1:0] o_c,
    output logic                        o_validResult,
    input  logic                        i_readyResult,
    output logic                        o_busy
);
    localparam int              c_CW       = $clog2(3 * N);
    // Operands reach PE(i,j) one cycle after injection, so the last product
    // (k=i=j=N-1) lands at counter 3N-2.
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(3 * N - 2);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                      r_state;
    logic [c_CW-1:0]             r_cnt;
    logic                        r_valid;
    logic                        r_busy;
    logic                        r_signed;
    logic [N-1:0][N-1:0][DW-1:0] r_amat;
    logic [N-1:0][N-1:0][DW-1:0] r_bmat;

    logic [DW-1:0] r_pa  [N][N];
    logic [DW-1:0] r_pb  [N][N];
    logic [AW-1:0] r_acc [N][N];

    logic [DW-1:0] w_afeed [N];
    logic [DW-1:0] w_bfeed [N];
    logic          w_accept;
    logic          w_compute;

    assign o_readyInput  = (r_state == S_IDLE) | ((r_state == S_DONE) & i_readyResult);
    assign w_accept      = i_validInput & o_readyInput;
    assign w_compute     = (r_state == S_COMPUTE);
    assign o_validResult = r_valid;
    assign o_busy        = r_busy;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_signed <= 1'b0;
            r_amat   <= '0;
            r_bmat   <= '0;
        end else begin
            if (w_accept) begin
                r_amat   <= i_a;
                r_bmat   <= i_b;
                r_signed <= i_signed;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_COMPUTE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_COMPUTE: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_readyResult) begin
                        r_valid <= 1'b0;
                        if (w_accept) begin
                            r_state <= S_COMPUTE;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Skewed injection: row i of A / column j of B start i / j cycles late.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_afeed[i] = '0;
            w_bfeed[i] = '0;
            for (int k = 0; k < N; k++) begin
                if (w_compute && (r_cnt == c_CW'(i + k))) begin
                    w_afeed[i] = r_amat[i][k];
                    w_bfeed[i] = r_bmat[k][i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                o_c[i][j] = r_acc[i][j];
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic [DW-1:0]          w_ain;
            logic [DW-1:0]          w_bin;
            logic signed [2*DW+1:0] w_ax;
            logic signed [2*DW+1:0] w_bx;
            logic signed [2*DW+1:0] w_p;
            logic [AW-1:0]          w_prod;

            if (gj == 0) begin : g_a_edge
                assign w_ain = w_afeed[gi];
            end else begin : g_a_pass
                assign w_ain = r_pa[gi][gj-1];
            end

            if (gi == 0) begin : g_b_edge
                assign w_bin = w_bfeed[gj];
            end else begin : g_b_pass
                assign w_bin = r_pb[gi-1][gj];
            end

            always_comb begin
                w_ax   = r_signed ? {{(DW+2){r_pa[gi][gj][DW-1]}}, r_pa[gi][gj]}
                                  : {{(DW+2){1'b0}}, r_pa[gi][gj]};
                w_bx   = r_signed ? {{(DW+2){r_pb[gi][gj][DW-1]}}, r_pb[gi][gj]}
                                  : {{(DW+2){1'b0}}, r_pb[gi][gj]};
                w_p    = w_ax * w_bx;
                w_prod = AW'(w_p);
            end

            always_ff @(posedge i_clk or negedge i_arst_n) begin
                if (!i_arst_n) begin
                    r_pa[gi][gj]  <= '0;
                    r_pb[gi][gj]  <= '0;
                    r_acc[gi][gj] <= '0;
                end else begin
                    r_pa[gi][gj] <= w_ain;
                    r_pb[gi][gj] <= w_bin;
                    if (w_accept && !i_accumulate) begin
                        r_acc[gi][gj] <= '0;
                    end else if (w_compute) begin
                        r_acc[gi][gj] <= r_acc[gi][gj] + w_prod;
                    end
                end
            end
        end
    end
endmodule
`default_nettype wire
